// File: rtl/bp_zynq_cfg_sequencer.sv
// rtl/bp_zynq_cfg_sequencer.sv - boot-time cfg write sequencer for BlackParrot cores
// Optional ack watchdog: define BP_ZYNQ_CFG_SEQ_TIMEOUT_EN.
module bp_zynq_cfg_sequencer
  #(parameter int num_core_p = 1
  , parameter int core_id_width_p = 4
  , parameter int cfg_addr_width_p = 20
  , parameter int cfg_data_width_p = 64
  , parameter int vaddr_width_p = 39
  , parameter logic [cfg_addr_width_p-1:0] freeze_addr_p = 20'h0008
  , parameter logic [cfg_addr_width_p-1:0] npc_addr_p = 20'h0010
  , parameter logic [cfg_addr_width_p-1:0] icache_mode_addr_p = 20'h0018
  , parameter logic [cfg_addr_width_p-1:0] dcache_mode_addr_p = 20'h0020
  , parameter logic [cfg_addr_width_p-1:0] cce_mode_addr_p = 20'h0028
  , parameter int timeout_cycles_p = 1024
  )
  (input  logic                        clk_i
  , input  logic                        reset_i
  , input  logic                        start_i
  , input  logic [vaddr_width_p-1:0]    npc_i
  , input  logic [1:0]                  icache_mode_i
  , input  logic [1:0]                  dcache_mode_i
  , input  logic [1:0]                  cce_mode_i
  , output logic                        cfg_v_o
  , input  logic                        cfg_ready_and_i
  , output logic [core_id_width_p-1:0]  cfg_core_o
  , output logic [cfg_addr_width_p-1:0] cfg_addr_o
  , output logic [cfg_data_width_p-1:0] cfg_data_o
  , input  logic                        cfg_ack_i
  , output logic                        busy_o
  , output logic                        done_o
  , output logic                        error_o
  );

  localparam int cnt_width_lp = $clog2(num_core_p+1);
  localparam logic [cnt_width_lp-1:0] last_core_lp = cnt_width_lp'(num_core_p);

  typedef enum logic [2:0] {e_idle, e_issue, e_wait_ack, e_done, e_error} state_e;
  typedef enum logic {e_config, e_release} phase_e;

  state_e state_r;
  phase_e phase_r, phase_n;
  logic [2:0] step_r, step_n;
  logic [cnt_width_lp-1:0] core_cnt_r, core_cnt_n, core_cnt_inc;
  logic seq_last;
  logic [vaddr_width_p-1:0] npc_r;
  logic [1:0] icache_mode_r, dcache_mode_r, cce_mode_r;
  logic [cfg_addr_width_p-1:0] addr_n;
  logic [cfg_data_width_p-1:0] data_n;
  logic in_seq, handshake, progress, timeout_hit;

  assign in_seq    = (state_r == e_issue) || (state_r == e_wait_ack);
  assign handshake = cfg_v_o & cfg_ready_and_i;
  // An ack landing on the handshake cycle completes the write without visiting WAIT_ACK
  assign progress  = ((state_r == e_issue) & handshake & cfg_ack_i)
                   | ((state_r == e_wait_ack) & cfg_ack_i);

  always_comb begin
    core_cnt_inc = core_cnt_r + cnt_width_lp'(1);
    phase_n      = phase_r;
    step_n       = step_r + 3'd1;
    core_cnt_n   = core_cnt_r;
    seq_last     = 1'b0;
    if (phase_r == e_config) begin
      if (step_r == 3'd4) begin
        step_n = 3'd0;
        if (core_cnt_inc == last_core_lp) begin
          phase_n    = e_release;
          core_cnt_n = '0;
        end else begin
          core_cnt_n = core_cnt_inc;
        end
      end
    end else begin
      step_n     = 3'd0;
      core_cnt_n = core_cnt_inc;
      seq_last   = (core_cnt_inc == last_core_lp);
    end
  end

  always_comb begin
    addr_n = freeze_addr_p;
    data_n = '0;
    if (phase_n == e_config) begin
      case (step_n)
        3'd0: data_n[0] = 1'b1;
        3'd1: begin addr_n = icache_mode_addr_p; data_n = cfg_data_width_p'(icache_mode_r); end
        3'd2: begin addr_n = dcache_mode_addr_p; data_n = cfg_data_width_p'(dcache_mode_r); end
        3'd3: begin addr_n = cce_mode_addr_p;    data_n = cfg_data_width_p'(cce_mode_r);    end
        3'd4: begin addr_n = npc_addr_p;         data_n = cfg_data_width_p'(npc_r);         end
        default: ;
      endcase
    end
  end

`ifdef BP_ZYNQ_CFG_SEQ_TIMEOUT_EN
  localparam int wd_width_lp = $clog2(timeout_cycles_p+1);
  logic [wd_width_lp-1:0] wd_cnt_r;

  // Counts cycles spent on the current write; any completed write restarts it
  always_ff @(posedge clk_i) begin
    if (reset_i || !in_seq || progress)
      wd_cnt_r <= '0;
    else
      wd_cnt_r <= wd_cnt_r + wd_width_lp'(1);
  end

  assign timeout_hit = in_seq && !progress
                    && (wd_cnt_r == wd_width_lp'(timeout_cycles_p-1));
`else
  localparam int unused_timeout_lp = timeout_cycles_p;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_idle;
      phase_r       <= e_config;
      step_r        <= '0;
      core_cnt_r    <= '0;
      npc_r         <= '0;
      icache_mode_r <= '0;
      dcache_mode_r <= '0;
      cce_mode_r    <= '0;
      cfg_v_o       <= 1'b0;
      cfg_core_o    <= '0;
      cfg_addr_o    <= '0;
      cfg_data_o    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      case (state_r)
        e_issue, e_wait_ack: begin
          if (progress) begin
            phase_r    <= phase_n;
            step_r     <= step_n;
            core_cnt_r <= core_cnt_n;
            if (seq_last) begin
              state_r <= e_done;
              cfg_v_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              state_r    <= e_issue;
              cfg_v_o    <= 1'b1;
              cfg_core_o <= core_id_width_p'(core_cnt_n);
              cfg_addr_o <= addr_n;
              cfg_data_o <= data_n;
            end
          end else if (timeout_hit) begin
            state_r <= e_error;
            cfg_v_o <= 1'b0;
            busy_o  <= 1'b0;
            error_o <= 1'b1;
          end else if (handshake) begin
            state_r <= e_wait_ack;
            cfg_v_o <= 1'b0;
          end
        end
        default: begin
          // IDLE, DONE and ERROR all accept a fresh start
          if (start_i) begin
            state_r       <= e_issue;
            phase_r       <= e_config;
            step_r        <= '0;
            core_cnt_r    <= '0;
            npc_r         <= npc_i;
            icache_mode_r <= icache_mode_i;
            dcache_mode_r <= dcache_mode_i;
            cce_mode_r    <= cce_mode_i;
            cfg_v_o       <= 1'b1;
            cfg_core_o    <= '0;
            cfg_addr_o    <= freeze_addr_p;
            cfg_data_o    <= cfg_data_width_p'(1);
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_zynq_cfg_sequencer.sv
// tb/tb_bp_zynq_cfg_sequencer.sv - self-checking bench for bp_zynq_cfg_sequencer
// Timeout scenario runs only when BP_ZYNQ_CFG_SEQ_TIMEOUT_EN is defined.
module tb_bp_zynq_cfg_sequencer;
  localparam int N = 2;
  localparam int MAX_CYC = 2000;

  typedef struct packed {
    logic [3:0]  core;
    logic [19:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_i, start_i, cfg_ready_and_i, cfg_ack_i;
  logic [38:0] npc_i;
  logic [1:0]  icache_mode_i, dcache_mode_i, cce_mode_i;
  logic        cfg_v_o, busy_o, done_o, error_o;
  logic [3:0]  cfg_core_o;
  logic [19:0] cfg_addr_o;
  logic [63:0] cfg_data_o;

  int vectors = 0;
  int miscompares = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int lat, err_at;
  bit stable_err, busy_err;

  always #5 clk = ~clk;

  bp_zynq_cfg_sequencer #(.num_core_p(N), .timeout_cycles_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .npc_i(npc_i),
    .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
    .cfg_v_o(cfg_v_o), .cfg_ready_and_i(cfg_ready_and_i), .cfg_core_o(cfg_core_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ack_i(cfg_ack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o));

  // Expected write stream: five config writes per core, then one unfreeze per core
  task automatic build_model(input logic [38:0] npc, input logic [1:0] ic,
                             input logic [1:0] dc, input logic [1:0] cm);
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00008, data: 64'd1});
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00018, data: 64'(ic)});
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00020, data: 64'(dc)});
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00028, data: 64'(cm)});
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00010, data: 64'(npc)});
    end
    for (int c = 0; c < N; c++)
      exp_q.push_back(wr_t'{core: 4'(c), addr: 20'h00008, data: 64'd0});
  endtask

  function automatic int first_diff();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic do_start(input logic [38:0] npc, input logic [1:0] ic,
                          input logic [1:0] dc, input logic [1:0] cm);
    @(negedge clk);
    npc_i = npc; icache_mode_i = ic; dcache_mode_i = dc; cce_mode_i = cm;
    cfg_ready_and_i = 1'b0; cfg_ack_i = 1'b0; start_i = 1'b1;
  endtask

  // Cycle-by-cycle responder and monitor; cycle 1 is the first cycle after the start edge
  task automatic run_seq(input int ready_mode, input int ack_lo, input int ack_hi,
                         input int mid_start_at, input int reset_after_hs,
                         input int withhold_idx, input bit spurious);
    bit pend, npc_stalled, stalled_prev, ack, rdy;
    int pend_wait, hs_cnt, stall_left, low_run, d;
    wr_t held, cur;
    got_q.delete();
    lat = -1; err_at = -1; stable_err = 0; busy_err = 0;
    pend = 0; pend_wait = 0; hs_cnt = 0; stall_left = 0; npc_stalled = 0;
    low_run = 0; stalled_prev = 0; held = '0;
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      @(negedge clk);
      start_i = (cyc == mid_start_at);
      if (cyc == 1 || start_i) begin
        npc_i = 39'({$urandom(), $urandom()});
        icache_mode_i = 2'($urandom_range(0, 3));
        dcache_mode_i = 2'($urandom_range(0, 3));
        cce_mode_i    = 2'($urandom_range(0, 3));
      end
      cur = wr_t'{cfg_core_o, cfg_addr_o, cfg_data_o};
      if (done_o || error_o) begin
        if (done_o) lat = cyc; else err_at = cyc;
        cfg_ack_i = 1'b0; cfg_ready_and_i = 1'b0; start_i = 1'b0;
        break;
      end
      if (!busy_o) busy_err = 1;
      if (stalled_prev && (!cfg_v_o || cur !== held)) stable_err = 1;
      ack = 0;
      if (pend) begin
        if (pend_wait == 0) begin ack = 1; pend = 0; end
        else pend_wait--;
      end
      case (ready_mode)
        1: begin
          rdy = ($urandom_range(0, 3) != 0) || (low_run >= 3);
          low_run = rdy ? 0 : low_run + 1;
        end
        2: begin
          if (cfg_v_o && cfg_addr_o == 20'h00010 && !npc_stalled) begin
            stall_left = 5; npc_stalled = 1;
          end
          rdy = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: rdy = 1;
      endcase
      cfg_ready_and_i = rdy;
      if (cfg_v_o && rdy) begin
        got_q.push_back(cur);
        hs_cnt++;
        stalled_prev = 0;
        if (hs_cnt - 1 != withhold_idx) begin
          d = $urandom_range(ack_hi, ack_lo);
          if (d == 0) ack = 1;
          else begin pend = 1; pend_wait = d - 1; end
        end
      end else begin
        stalled_prev = cfg_v_o;
        held = cur;
        if (spurious && cfg_v_o && !pend && !ack) ack = ($urandom_range(0, 1) == 1);
      end
      cfg_ack_i = ack;
      if (reset_after_hs > 0 && hs_cnt == reset_after_hs) break;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 0; cfg_ready_and_i = 0; cfg_ack_i = 0;
    npc_i = '0; icache_mode_i = '0; dcache_mode_i = '0; cce_mode_i = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cfg_v_o, busy_o, done_o, error_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: v/busy/done/error=%b required 0000", {cfg_v_o, busy_o, done_o, error_o});
    end
    vectors++;
    if (cfg_core_o !== 4'd0) begin miscompares++; $display("FAIL reset_core: got %0d required 0", cfg_core_o); end
    vectors++;
    if (cfg_addr_o !== 20'd0) begin miscompares++; $display("FAIL reset_addr: got %h required 0", cfg_addr_o); end
    vectors++;
    if (cfg_data_o !== 64'd0) begin miscompares++; $display("FAIL reset_data: got %h required 0", cfg_data_o); end
    reset_i = 1'b0;
    cfg_ack_i = 1'b1;
    @(negedge clk);
    cfg_ack_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cfg_v_o, busy_o, done_o} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_ack_ignored: v/busy/done=%b required 000", {cfg_v_o, busy_o, done_o});
    end
  endtask

  task automatic test_basic();
    int d;
    build_model(39'h80000000, 2'd1, 2'd1, 2'd1);
    do_start(39'h80000000, 2'd1, 2'd1, 2'd1);
    run_seq(0, 0, 0, 0, 0, -1, 0);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL basic_count: got %0d writes required %0d", got_q.size(), exp_q.size());
    end
    d = first_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL basic_write: #%0d got core=%0d addr=%h data=%h required core=%0d addr=%h data=%h",
               d, got_q[d].core, got_q[d].addr, got_q[d].data, exp_q[d].core, exp_q[d].addr, exp_q[d].data);
    end
    vectors++;
    if (lat !== 1 + 6 * N) begin miscompares++; $display("FAIL basic_latency: got %0d required %0d", lat, 1 + 6 * N); end
    vectors++;
    if (busy_err !== 1'b0) begin miscompares++; $display("FAIL basic_busy: busy dropped early, flag=%0d required 0", busy_err); end
    repeat (3) @(negedge clk);
    vectors++;
    if ({done_o, busy_o, error_o, cfg_v_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL basic_sticky_done: done/busy/error/v=%b required 1000", {done_o, busy_o, error_o, cfg_v_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [38:0] npc;
    logic [1:0] ic, dc, cm;
    int d;
    for (int it = 0; it < 6; it++) begin
      npc = 39'({$urandom(), $urandom()});
      ic = 2'($urandom_range(0, 3)); dc = 2'($urandom_range(0, 3)); cm = 2'($urandom_range(0, 3));
      build_model(npc, ic, dc, cm);
      do_start(npc, ic, dc, cm);
      run_seq(1, 0, 4, 0, 0, -1, 1);
      vectors++;
      if (got_q.size() !== exp_q.size() || lat < 0) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: got %0d writes (done at %0d) required %0d", it, got_q.size(), lat, exp_q.size());
      end
      d = first_diff();
      vectors++;
      if (d !== -1) begin
        miscompares++;
        $display("FAIL rand_write[%0d]: #%0d got core=%0d addr=%h data=%h required core=%0d addr=%h data=%h",
                 it, d, got_q[d].core, got_q[d].addr, got_q[d].data, exp_q[d].core, exp_q[d].addr, exp_q[d].data);
      end
      vectors++;
      if (stable_err !== 1'b0) begin miscompares++; $display("FAIL rand_stable[%0d]: flag=%0d required 0", it, stable_err); end
      vectors++;
      if (busy_err !== 1'b0) begin miscompares++; $display("FAIL rand_busy[%0d]: flag=%0d required 0", it, busy_err); end
    end
  endtask

  task automatic test_ready_stall();
    int d, npc_hs;
    build_model(39'h12345678, 2'd2, 2'd3, 2'd0);
    do_start(39'h12345678, 2'd2, 2'd3, 2'd0);
    run_seq(2, 0, 0, 0, 0, -1, 0);
    npc_hs = 0;
    foreach (got_q[i]) if (got_q[i].addr == 20'h00010) npc_hs++;
    vectors++;
    if (npc_hs !== N) begin miscompares++; $display("FAIL stall_npc_handshakes: got %0d required %0d", npc_hs, N); end
    vectors++;
    if (stable_err !== 1'b0) begin miscompares++; $display("FAIL stall_stable: flag=%0d required 0", stable_err); end
    d = first_diff();
    vectors++;
    if (d !== -1 || got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL stall_writes: diff at %0d, count %0d required %0d", d, got_q.size(), exp_q.size());
    end
    vectors++;
    if (lat !== 1 + 6 * N + 5) begin miscompares++; $display("FAIL stall_latency: got %0d required %0d", lat, 1 + 6 * N + 5); end
  endtask

  task automatic test_ack_delay_mid_start();
    int d;
    build_model(39'h7f_0000_1000, 2'd3, 2'd2, 2'd1);
    do_start(39'h7f_0000_1000, 2'd3, 2'd2, 2'd1);
    run_seq(0, 3, 3, 10, 0, -1, 0);
    vectors++;
    if (got_q.size() !== 6 * N) begin miscompares++; $display("FAIL delay_count: got %0d required %0d", got_q.size(), 6 * N); end
    d = first_diff();
    vectors++;
    if (d !== -1) begin
      miscompares++;
      $display("FAIL delay_write: #%0d got addr=%h data=%h required addr=%h data=%h",
               d, got_q[d].addr, got_q[d].data, exp_q[d].addr, exp_q[d].data);
    end
    vectors++;
    if (busy_err !== 1'b0) begin miscompares++; $display("FAIL delay_busy: flag=%0d required 0", busy_err); end
    vectors++;
    if (lat !== 1 + 4 * 6 * N) begin miscompares++; $display("FAIL delay_latency: got %0d required %0d", lat, 1 + 4 * 6 * N); end
  endtask

  task automatic test_reset_mid();
    int d;
    bit saw_v;
    build_model(39'h1000, 2'd1, 2'd2, 2'd3);
    do_start(39'h1000, 2'd1, 2'd2, 2'd3);
    run_seq(0, 0, 2, 0, 3, -1, 0);
    @(negedge clk);
    reset_i = 1'b1; cfg_ack_i = 1'b0; cfg_ready_and_i = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cfg_v_o, busy_o, done_o, error_o} !== 4'b0 || cfg_core_o !== 4'd0
        || cfg_addr_o !== 20'd0 || cfg_data_o !== 64'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: v/busy/done/error=%b core=%0d addr=%h data=%h required all 0",
               {cfg_v_o, busy_o, done_o, error_o}, cfg_core_o, cfg_addr_o, cfg_data_o);
    end
    reset_i = 1'b0;
    saw_v = 0;
    repeat (4) begin @(negedge clk); if (cfg_v_o) saw_v = 1; end
    vectors++;
    if (saw_v !== 1'b0) begin miscompares++; $display("FAIL midreset_no_unfreeze: cfg_v_o seen=%0d required 0", saw_v); end
    build_model(39'h2_0000_0040, 2'd0, 2'd1, 2'd2);
    do_start(39'h2_0000_0040, 2'd0, 2'd1, 2'd2);
    run_seq(1, 0, 2, 0, 0, -1, 0);
    d = first_diff();
    vectors++;
    if (d !== -1 || got_q.size() !== exp_q.size() || lat < 0) begin
      miscompares++; $display("FAIL midreset_replay: diff at %0d, count %0d required %0d", d, got_q.size(), exp_q.size());
    end
  endtask

`ifdef BP_ZYNQ_CFG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit bad;
    build_model(39'h4000, 2'd1, 2'd1, 2'd1);
    do_start(39'h4000, 2'd1, 2'd1, 2'd1);
    run_seq(0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (err_at !== 18) begin miscompares++; $display("FAIL timeout_cycle: error at %0d required 18", err_at); end
    vectors++;
    if (got_q.size() !== 2) begin miscompares++; $display("FAIL timeout_writes: got %0d required 2", got_q.size()); end
    cfg_ready_and_i = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cfg_v_o || done_o || !error_o || busy_o) bad = 1;
    end
    cfg_ready_and_i = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("FAIL timeout_hold: bad flag=%0d required 0", bad); end
    do_start(39'h4000, 2'd1, 2'd1, 2'd1);
    run_seq(0, 0, 1, 0, 0, -1, 0);
    vectors++;
    if (lat < 0 || error_o !== 1'b0 || first_diff() !== -1) begin
      miscompares++; $display("FAIL timeout_restart: done at %0d error=%0d required done and error 0", lat, error_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ready_stall();
    test_ack_delay_mid_start();
    test_reset_mid();
`ifdef BP_ZYNQ_CFG_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/bp_zynq_cfg_sequencer.md
Name: bp_zynq_cfg_sequencer

Overview:
- Boot-time controller that programs every BlackParrot core's configuration registers over the cfg write channel.
- Triggered by a host (PS) start pulse. Writes, per core: freeze=1, icache mode, dcache mode, cce mode, npc. Then releases freeze on all cores.
- Sits between the zynq-parrot host CSR block and the per-core cfg bus.
- Supports the unicore and multicore zynqparrot configurations.

Parameters:
- num_core_p, 1, number of cores to program (1..16).
- core_id_width_p, 4, width of the core select field.
- cfg_addr_width_p, 20, cfg register address width.
- cfg_data_width_p, 64, cfg write data width.
- vaddr_width_p, 39, npc width.
- freeze_addr_p, 20'h0008, freeze register address.
- npc_addr_p, 20'h0010, npc register address.
- icache_mode_addr_p, 20'h0018, icache mode register address.
- dcache_mode_addr_p, 20'h0020, dcache mode register address.
- cce_mode_addr_p, 20'h0028, cce mode register address.
- timeout_cycles_p, 1024, ack watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start pulse from host CSR.
- npc_i  in  vaddr_width_p  boot PC; latched on accepted start.
- icache_mode_i  in  2  icache mode; latched on accepted start.
- dcache_mode_i  in  2  dcache mode; latched on accepted start.
- cce_mode_i  in  2  cce mode; latched on accepted start.
- cfg_v_o  out  1  write valid.
- cfg_ready_and_i  in  1  write ready.
- cfg_core_o  out  core_id_width_p  target core.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- cfg_ack_i  in  1  write-complete pulse; exactly one per accepted write.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete; sticky until next accepted start.
- error_o  out  1  watchdog fired; sticky until next accepted start.

Behaviour:
- Reset: state=IDLE, and every output is 0 (cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, busy_o, done_o, error_o).
- Reset mid-sequence aborts the sequence immediately. No unfreeze writes are issued.
- States: IDLE, ISSUE, WAIT_ACK, DONE, ERROR.
- IDLE:
  - start_i=1 latches the inputs, clears done_o and error_o, and sets core_cnt=0, step=0, phase=CONFIG.
  - Next state is ISSUE; busy_o=1 from the next cycle.
- ISSUE: cfg_v_o=1 with addr/data chosen by step. Address and data must stay stable until handshake.
  - CONFIG phase steps 0..4: (freeze_addr_p, 1), (icache_mode_addr_p, icache_mode), (dcache_mode_addr_p, dcache_mode), (cce_mode_addr_p, cce_mode), (npc_addr_p, npc).
  - RELEASE phase step 0: (freeze_addr_p, 0).
  - The handshake (cfg_v_o & cfg_ready_and_i) moves to WAIT_ACK. cfg_v_o drops the following cycle.
- WAIT_ACK: at most one write is outstanding.
  - On cfg_ack_i, advance the step.
  - After CONFIG step 4: core_cnt++. When core_cnt reaches num_core_p, switch to RELEASE with core_cnt=0.
  - After the RELEASE write: core_cnt++. When core_cnt reaches num_core_p, go to DONE; otherwise go to ISSUE.
  - An ack that arrives in the same cycle as the handshake is legal and is counted. The FSM goes directly to the next ISSUE state one cycle later.
- DONE: busy_o=0, done_o=1. start_i restarts the full sequence.
- ERROR: busy_o=0, error_o=1, done_o=0. start_i restarts the full sequence.
- start_i while busy is ignored, and the latched values are not changed.
- cfg_ack_i outside WAIT_ACK is ignored.
- Total writes = 6*num_core_p.
- Minimum latency, start to done_o, with ready and ack both tied to 1: 1 + 6*num_core_p cycles.
- Counter widths: core_cnt is $clog2(num_core_p+1) bits; step is 3 bits.

Optional Feature:
- Macro: BP_ZYNQ_CFG_SEQ_TIMEOUT_EN.
- Enabled: a watchdog counter resets on entry to ISSUE and counts every cycle spent in ISSUE or WAIT_ACK.
  - When it reaches timeout_cycles_p, the FSM goes to ERROR, cfg_v_o=0 immediately, and the remaining writes are abandoned.
  - An ack in the same cycle as the timeout wins, and the sequence proceeds.
- Disabled: no counter and no ERROR state is reachable. error_o is tied to 0, and the block waits indefinitely for ack.

Test Plan:
- num_core_p=1, ready=ack=1, npc=39'h80000000, modes 1/1/1 -> writes (0x08,1), (0x18,1), (0x20,1), (0x28,1), (0x10,0x80000000), (0x08,0); done_o at cycle 7.
- num_core_p=2 -> 10 config writes with cores ordered 0,0,0,0,0,1,1,1,1,1, then unfreeze writes to core 0 then core 1.
- cfg_ready_and_i low for 5 cycles on the npc write -> cfg_v_o, addr and data stable throughout; exactly one handshake.
- Ack delayed 3 cycles per write, plus a start pulse mid-sequence -> second start is ignored; total 6 writes; busy_o high until done.
- reset_i asserted after the 3rd handshake -> all outputs 0 next cycle; a new start replays the full 6-write sequence.
- With BP_ZYNQ_CFG_SEQ_TIMEOUT_EN and timeout_cycles_p=16, ack withheld on the 2nd write -> error_o=1 exactly 16 cycles after ISSUE entry, no further cfg_v_o, done_o=0.
